// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer: state encoding,
// in-flight write entry layout and the source/entry match helper.
package hazard_pkg;

    localparam int          PIPE_DEPTH = 3;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic [15:0] STALL_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } entry_t;

    // r0 is hard-wired zero, so reading it can never depend on a pending write.
    function automatic logic src_hit(input logic used, input logic [4:0] src, input entry_t e);
        return used && (src != REG_ZERO) && e.valid && (e.rd == src);
    endfunction

endpackage

// File: rtl/inflight_tracker.sv
// Shift register of pending register writes (EX, MEM, WB) and the RAW match
// against the sources of the instruction currently in ID.
module inflight_tracker
    import hazard_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       issue,
    input  logic [4:0] ID_Rd,
    input  logic       ID_RegWrite,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic       uses_Rs,
    input  logic       uses_Rt,
    output logic       hazard
);

    entry_t entry_q [PIPE_DEPTH];
    entry_t entry_d [PIPE_DEPTH];

    always_comb begin
        entry_d[0] = '0;
        if (issue) begin
            entry_d[0].valid = ID_RegWrite && (ID_Rd != REG_ZERO);
            entry_d[0].rd    = ID_Rd;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            entry_d[i] = entry_q[i-1];
        end
    end

    // No forwarding: every stage up to and including WB blocks the read.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            hazard = hazard
                   | src_hit(uses_Rs, IF_ID_Rs, entry_q[i])
                   | src_hit(uses_Rt, IF_ID_Rt, entry_q[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// ID-stage hazard sequencer: stalls on RAW hazards against in-flight writes,
// flushes the fetch slot after a resolved control transfer, counts stall cycles.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal issue; may stall on a hazard or flush on a transfer
//   ST_STALL | ID instruction held waiting for its operands to retire
//   ST_FLUSH | slot behind a taken transfer is discarded; nothing issues
module hazard_sequencer
    import hazard_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        uses_Rs,
    input  logic        uses_Rt,
    input  logic [4:0]  ID_Rd,
    input  logic        ID_RegWrite,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        control,
    output logic        IF_ID_flush,
    output logic        stall_active,
    output logic [15:0] stall_cycles
);

    state_t      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        hazard;
    logic        issue;

    inflight_tracker u_tracker (
        .Clk         (Clk),
        .Reset       (Reset),
        .issue       (issue),
        .ID_Rd       (ID_Rd),
        .ID_RegWrite (ID_RegWrite),
        .IF_ID_Rs    (IF_ID_Rs),
        .IF_ID_Rt    (IF_ID_Rt),
        .uses_Rs     (uses_Rs),
        .uses_Rt     (uses_Rt),
        .hazard      (hazard)
    );

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        control      = 1'b1;
        IF_ID_flush  = 1'b0;
        stall_active = 1'b0;
        issue        = 1'b0;
        state_d      = state_q;
        if (Reset) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_FLUSH: state_d = ST_RUN;
                default: begin
                    // Hazard wins over a transfer so jumpReg/branches see valid operands.
                    if (hazard) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        control      = 1'b0;
                        stall_active = 1'b1;
                        state_d      = ST_STALL;
                    end else begin
                        issue = 1'b1;
                        if (jump || jumpReg || branch_taken) begin
                            IF_ID_Write = 1'b0;
                            IF_ID_flush = 1'b1;
                            state_d     = ST_FLUSH;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_active && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports IF_ID_Rs, IF_ID_Rt, input, 5 each, source registers of the instruction in the ID stage.
REQ-004 SHALL have ports uses_Rs, uses_Rt, input, 1 each, high when the ID instruction reads that source.
REQ-005 SHALL have ports ID_Rd (input, 5) and ID_RegWrite (input, 1): destination and write-enable of the ID instruction.
REQ-006 SHALL have ports jump, jumpReg, branch_taken, input, 1 each, control transfer resolved in ID.
REQ-007 SHALL have ports PCWrite, IF_ID_Write, control, IF_ID_flush, output, 1 each, pipeline steering (control=0 inserts a bubble).
REQ-008 SHALL have ports stall_active (output, 1) and stall_cycles (output, 16): status.

Function
REQ-009 SHALL track three in-flight write entries {valid, rd}: E0 = EX, E1 = MEM, E2 = WB.
REQ-010 SHALL advance the entries every cycle: E2<=E1 and E1<=E0. E0 loads {ID_RegWrite && ID_Rd!=0, ID_Rd} when issuing, otherwise {0, 0}.
REQ-011 SHALL define "issuing" as true in RUN or STALL when hazard=0, and false in FLUSH.
REQ-012 SHALL define hazard as (uses_Rs && IF_ID_Rs!=0 && IF_ID_Rs matches any valid entry) || (same condition for Rt). There is no forwarding, and E2 counts as a match.
REQ-013 SHALL implement an FSM with states RUN, STALL and FLUSH.
REQ-014 SHALL, in RUN or STALL with hazard=1, drive PCWrite=0, IF_ID_Write=0, control=0, IF_ID_flush=0, and set next state STALL.
REQ-015 SHALL, in RUN or STALL with hazard=0 and (jump|jumpReg|branch_taken)=1, drive PCWrite=1, IF_ID_Write=0, control=1, IF_ID_flush=1, and set next state FLUSH.
REQ-016 SHALL, in RUN or STALL with hazard=0 and no control transfer, drive 1,1,1,0 and set next state RUN.
REQ-017 SHALL, in FLUSH, drive 1,1,1,0 regardless of inputs and set next state RUN. A control transfer on the flushed slot is ignored.
REQ-018 SHALL give hazard priority over control transfer, so jumpReg and branches wait for their operands.
REQ-019 SHALL compute the steering outputs combinationally from registered state and current inputs, with no added latency.
REQ-020 SHALL drive stall_active=1 exactly when the REQ-014 condition holds.
REQ-021 SHALL increment stall_cycles by 1 on each clock edge where stall_active=1, saturating at 0xFFFF.
REQ-022 SHALL bound any single stall to at most 3 consecutive cycles.

Reset
REQ-023 SHALL, on a Reset=1 edge, set the state to RUN, clear all entries (valid=0, rd=0), and set stall_cycles to 0.
REQ-024 SHALL, while Reset=1, force PCWrite=1, IF_ID_Write=1, control=1, IF_ID_flush=0 and stall_active=0.
REQ-025 SHALL give Reset priority over every other event, including mid-STALL and mid-FLUSH. Pending entries are discarded.

Structure
REQ-026 SHALL take the state encoding, PIPE_DEPTH=3 and REG_ZERO=5'd0 from the shared package hazard_pkg.
REQ-027 SHALL place the entry shift register and match comparators in one sub-module, inflight_tracker. The FSM and counter stay in hazard_sequencer.

Verification
REQ-028 Reset test: hold Reset=1 for 2 cycles -> outputs 1,1,1,0; stall_active=0; stall_cycles=0; no stall on the next instruction with Rs=5.
REQ-029 RAW test: cycle0 issue ID_Rd=5, ID_RegWrite=1; cycle1 IF_ID_Rs=5, uses_Rs=1 -> stall in cycles 1-3, issue in cycle 4, stall_cycles=3.
REQ-030 Zero-register test: issue ID_Rd=0, ID_RegWrite=1, then IF_ID_Rs=0, uses_Rs=1 -> no stall, outputs 1,1,1,0.
REQ-031 jumpReg test: Rd=31 in E1, then jumpReg=1 with IF_ID_Rs=31 -> stall 2 cycles, then 1 cycle of PCWrite=1, IF_ID_Write=0, control=1, IF_ID_flush=1, then FLUSH (1,1,1,0), then RUN.
REQ-032 Branch test: branch_taken=1 with no hazard -> IF_ID_flush=1 for one cycle. A branch_taken=1 arriving in the following FLUSH cycle is ignored.
REQ-033 Reset-mid-stall test: Reset=1 in the second stall cycle -> next cycle in RUN, entries cleared, outputs 1,1,1,0, stall_cycles=0.
